// File: rtl/wb_regfile.sv
// wb_regfile: writeback stage and architectural register file.
//
// Sits at the far end of the M/W latch. Selects the writeback destination and
// value, commits the write on the rising edge of `rise`, serves two
// combinational read ports with write-through bypass, and records the write
// committed at the previous edge so earlier stages can forward it.
//
// Ports:
//   rise                  clock, rising edge
//   reset                 asynchronous, active-low clear of all state
//   stall_wb              suppresses this cycle's commit
//   wen_mw, rd_mw,        M/W latch write enable and destination field
//   setx_mw, lw_mw,       M/W instruction type flags
//   jal_mw
//   pc_mw, target_mw,     writeback value candidates (jal link, setx target,
//   data_out_mw, mem_q    ALU result, load data)
//   ctrl_readA/B          read port indices
//   data_readA/B          read port data (0 for r0 and while reset is held)
//   wb_en/wb_rd/wb_data   the write that commits at the next edge
//   last_*_q              the write that committed at the previous edge

// One architectural register: a plain enable flop.
module wb_reg_cell #(
  parameter int WIDTH = 32
) (
  input  logic             rise,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge rise or negedge reset)
    if (!reset)  q <= '0;
    else if (en) q <= d;
endmodule

module wb_regfile #(
  parameter int NREGS    = 32,
  parameter int WIDTH    = 32,
  parameter int SETX_REG = 30,
  parameter int LINK_REG = 31
) (
  input  logic             rise,
  input  logic             reset,
  input  logic             stall_wb,
  input  logic             wen_mw,
  input  logic [4:0]       rd_mw,
  input  logic             setx_mw,
  input  logic             lw_mw,
  input  logic             jal_mw,
  input  logic [WIDTH-1:0] pc_mw,
  input  logic [WIDTH-1:0] target_mw,
  input  logic [WIDTH-1:0] data_out_mw,
  input  logic [WIDTH-1:0] mem_q,
  input  logic [4:0]       ctrl_readA,
  input  logic [4:0]       ctrl_readB,
  output logic [WIDTH-1:0] data_readA,
  output logic [WIDTH-1:0] data_readB,
  output logic             wb_en,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic             last_en_q,
  output logic [4:0]       last_rd_q,
  output logic [WIDTH-1:0] last_data_q
);

  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);
  localparam logic [4:0] SETX_IDX = 5'(SETX_REG);

  logic [WIDTH-1:0] rf_q   [NREGS];
  logic [NREGS-1:0] wen_dec;

  // Destination and value select; jal outranks setx outranks lw.
  always_comb begin
    wb_rd = rd_mw;
    if (jal_mw)       wb_rd = LINK_IDX;
    else if (setx_mw) wb_rd = SETX_IDX;

    wb_data = data_out_mw;
    if (jal_mw)       wb_data = pc_mw;
    else if (setx_mw) wb_data = target_mw;
    else if (lw_mw)   wb_data = mem_q;
  end

  assign wb_en = wen_mw & ~stall_wb & (wb_rd != 5'd0);

  // r0 has no storage; it is hardwired to zero.
  assign rf_q[0]    = '0;
  assign wen_dec[0] = 1'b0;

  for (genvar i = 1; i < NREGS; i++) begin : g_reg
    assign wen_dec[i] = wb_en & (wb_rd == 5'(i));
    wb_reg_cell #(.WIDTH(WIDTH)) u_cell (
      .rise  (rise),
      .reset (reset),
      .en    (wen_dec[i]),
      .d     (wb_data),
      .q     (rf_q[i])
    );
  end

  // Reads are forced to zero while reset is held so a pending write cannot
  // leak through the bypass path; otherwise a matching pending write wins.
  function automatic logic [WIDTH-1:0] read_port(input logic [4:0] idx);
    if (!reset || idx == 5'd0)      return '0;
    else if (wb_en && idx == wb_rd) return wb_data;
    else                            return rf_q[idx];
  endfunction

  assign data_readA = read_port(ctrl_readA);
  assign data_readB = read_port(ctrl_readB);

  // Last-write record: enable drops on idle cycles, payload holds.
  always_ff @(posedge rise or negedge reset)
    if (!reset) begin
      last_en_q   <= 1'b0;
      last_rd_q   <= '0;
      last_data_q <= '0;
    end else begin
      last_en_q <= wb_en;
      if (wb_en) begin
        last_rd_q   <= wb_rd;
        last_data_q <= wb_data;
      end
    end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Writeback stage and architectural register file. It is the consumer at the far end of the M/W pipeline latch.
- Takes the M/W latch fields, selects the writeback value and destination register, and commits the write on the clock edge.
- Serves two combinational read ports to decode, with write-through bypass.
- Keeps a one-cycle "last write" record so decode/execute bypass logic can forward a value retired in the previous cycle.

Parameters:
- NREGS, 32, number of architectural registers (fixed; index width 5)
- WIDTH, 32, data width in bits
- SETX_REG, 30, destination register for setx
- LINK_REG, 31, destination register for jal

Ports:
- rise  input  1  clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-low (0 = reset); clears all state immediately
- stall_wb  input  1  1 = suppress this cycle's commit (no regfile or last-write update)
- wen_mw  input  1  M/W latch write-enable (r-type, addi, lw, jal, setx)
- rd_mw  input  5  M/W latch rd field
- setx_mw  input  1  M/W instruction is setx
- lw_mw  input  1  M/W instruction is lw
- jal_mw  input  1  M/W instruction is jal
- pc_mw  input  32  M/W PC (already PC+1); link value for jal
- target_mw  input  32  M/W zero-extended target; value for setx
- data_out_mw  input  32  M/W ALU result
- mem_q  input  32  data-memory read data for the M/W instruction
- ctrl_readA  input  5  read port A index
- ctrl_readB  input  5  read port B index
- data_readA  output  32  read port A data
- data_readB  output  32  read port B data
- wb_en  output  1  combinational: a write commits at the next edge
- wb_rd  output  5  combinational: destination of that write
- wb_data  output  32  combinational: value of that write
- last_en_q  output  1  registered: a write committed at the previous edge
- last_rd_q  output  5  registered: destination of that write
- last_data_q  output  32  registered: value of that write

Behaviour:
- Reset (reset=0, asynchronous): all 32 registers cleared to 0; last_en_q=0, last_rd_q=0, last_data_q=0. It takes effect mid-cycle without waiting for rise. While reset is held, data_readA/B read 0 for every index.
- Destination select, priority order:
  - jal_mw=1 -> LINK_REG (31)
  - else setx_mw=1 -> SETX_REG (30)
  - else rd_mw
- Data select, priority order:
  - jal_mw -> pc_mw
  - else setx_mw -> target_mw
  - else lw_mw -> mem_q
  - else data_out_mw
- wb_en = wen_mw & ~stall_wb & (wb_rd != 0). wb_rd and wb_data always show the selected values, even when wb_en=0.
- Commit at rising edge of rise:
  - If wb_en=1: reg[wb_rd] <= wb_data; last_en_q <= 1; last_rd_q <= wb_rd; last_data_q <= wb_data.
  - If wb_en=0: regfile unchanged; last_en_q <= 0; last_rd_q and last_data_q hold their previous values.
- r0:
  - Never written; always reads 0.
  - A write targeting r0 is dropped and does not set last_en_q.
- Read ports (combinational, zero latency):
  - index 0 -> 0
  - else if wb_en=1 and index == wb_rd -> wb_data (write-through bypass in the same cycle)
  - else -> reg[index]
- Simultaneous events:
  - Both read ports may target the same register, and may both match wb_rd; both receive wb_data.
  - A conflicting instruction-type combination (e.g. jal_mw=1 with lw_mw=1) resolves by the priority order above; it cannot occur with legal encodings.
- Stall: with stall_wb=1 the M/W inputs are held by the latch. No state changes; reads return the pre-stall register contents with no bypass. The commit happens on the first edge after stall_wb falls.
- Reset asserted during a cycle with wb_en=1: the pending write is lost; reset wins.
- The register array uses per-register enable flops (one decoded enable per register); no latches.

Test Plan:
- Reset then read: reset=0 then release -> data_readA/B = 0 for indices 0..31; last_en_q = 0.
- r-type write: wen_mw=1, rd_mw=5, data_out_mw=0x0000_1234 -> same-cycle ctrl_readA=5 gives 0x1234 via bypass; after the edge reg5 = 0x1234, last_en_q=1, last_rd_q=5, last_data_q=0x1234.
- lw/jal/setx routing:
  - lw_mw=1, rd_mw=7, mem_q=0xDEADBEEF -> reg7 = 0xDEADBEEF.
  - jal_mw=1, rd_mw=3, pc_mw=0x40 -> reg31 = 0x40; reg3 unchanged.
  - setx_mw=1, target_mw=0x0012_3456 -> reg30 = 0x123456.
- r0 protection: wen_mw=1, rd_mw=0, data_out_mw=0xFFFF_FFFF -> data_readA(0) = 0 before and after the edge; last_en_q = 0.
- Stall: reg9=0x11, then stall_wb=1, wen_mw=1, rd_mw=9, data_out_mw=0x22 for 3 edges -> reg9 stays 0x11 and data_readB(9)=0x11 throughout; after stall_wb falls, one edge sets reg9 = 0x22.
- Async reset mid-write: wb_en=1 to rd=12, reset pulsed low between edges -> reg12 = 0 immediately, last_en_q = 0, no write at the following edge while reset is low.
